mem_access_unit: RTL

- Data-side memory access stage directly downstream of the load/store address unit.
- Accepts one load or store request at a time: effective address, funct3 size code and store data.
- Performs the access over a request/grant/rvalid memory port and returns sign/zero-extended load data to the register write-back path.
- Asserts busy_o so the core stalls while an access is outstanding.

---
 rtl/mem_access_unit.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Data-side memory access stage. Takes one load/store request at a time,
// runs it over a req/gnt/rvalid memory port and returns extended load data.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/ready_o     request handshake (ready only in IDLE)
//   req_we_i, req_funct3_i  store flag and RV32I size/sign code
//   req_addr_i, req_wdata_i byte address and store data
//   resp_valid_o            one-cycle completion pulse
//   resp_rdata_o/err_o      extended load data / error flag, held until next
//   busy_o                  access outstanding (state != IDLE)
//   mem_*                   memory port: request, byte enables, word address,
//                           lane-positioned write data, grant, rvalid, rdata
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Last counted REQ cycle without grant; reaching it ends the request.
  localparam logic [15:0] TMO_LAST_C = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_r, state_nxt_s;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;
  logic [31:0] mem_addr_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_wdata_r;
  logic [15:0] tmo_cnt_r, tmo_cnt_nxt_s;
  logic [31:0] rdata_r;
  logic        err_r;
  logic        accept_s;
  logic        capture_s;
  logic        capture_err_s;
  logic        req_ok_s;

  // funct3 legality: stores allow only SB/SH/SW, loads add LBU/LHU.
  function automatic logic f_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural alignment check by access size (funct3[1:0]).
  function automatic logic f_aligned(input logic [1:0] size, input logic [1:0] a);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~a[0];
      2'b10:   ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate narrow store data so the enabled lane always carries it.
  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      2'b10:   w = d;
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'd0;
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign req_ok_s = f_legal(req_we_i, req_funct3_i) &&
                    f_aligned(req_funct3_i[1:0], req_addr_i[1:0]);

  // Next-state, timeout counter and capture decisions.
  always_comb begin
    state_nxt_s   = state_r;
    tmo_cnt_nxt_s = tmo_cnt_r;
    accept_s      = 1'b0;
    capture_s     = 1'b0;
    capture_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept_s      = 1'b1;
          tmo_cnt_nxt_s = 16'd0;
          if (req_ok_s) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s   = ST_RESP;
            capture_s     = 1'b1;
            capture_err_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Grant is checked first so it wins in the final counted cycle.
        if (mem_gnt_i) begin
          state_nxt_s   = ST_WAIT;
          tmo_cnt_nxt_s = 16'd0;
        end else if (tmo_cnt_r == TMO_LAST_C) begin
          state_nxt_s   = ST_RESP;
          tmo_cnt_nxt_s = 16'd0;
          capture_s     = 1'b1;
          capture_err_s = 1'b1;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + 16'd1;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          state_nxt_s = ST_RESP;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      tmo_cnt_r <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end

  // Request latch: memory-port fields are formed once at accept and then held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_r        <= 1'b0;
      funct3_r    <= 3'd0;
      addr_lo_r   <= 2'd0;
      mem_addr_r  <= 32'd0;
      mem_be_r    <= 4'd0;
      mem_wdata_r <= 32'd0;
    end else if (accept_s) begin
      we_r        <= req_we_i;
      funct3_r    <= req_funct3_i;
      addr_lo_r   <= req_addr_i[1:0];
      mem_addr_r  <= {req_addr_i[31:2], 2'b00};
      mem_be_r    <= f_be(req_funct3_i[1:0], req_addr_i[1:0]);
      mem_wdata_r <= f_wdata(req_funct3_i[1:0], req_wdata_i);
    end else begin
      we_r        <= we_r;
      funct3_r    <= funct3_r;
      addr_lo_r   <= addr_lo_r;
      mem_addr_r  <= mem_addr_r;
      mem_be_r    <= mem_be_r;
      mem_wdata_r <= mem_wdata_r;
    end
  end

  // Response data/error: updated only on entry to RESP, held otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else if (capture_s) begin
      err_r   <= capture_err_s;
      rdata_r <= (capture_err_s || we_r) ? 32'd0 :
                 f_extract(funct3_r, addr_lo_r, mem_rdata_i);
    end else begin
      rdata_r <= rdata_r;
      err_r   <= err_r;
    end
  end

  assign req_ready_o  = (state_r == ST_IDLE);
  assign busy_o       = (state_r != ST_IDLE);
  assign mem_req_o    = (state_r == ST_REQ);
  assign resp_valid_o = (state_r == ST_RESP);
  assign resp_rdata_o = rdata_r;
  assign resp_err_o   = err_r;
  assign mem_we_o     = we_r;
  assign mem_be_o     = mem_be_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_wdata_o  = mem_wdata_r;

endmodule
